// File: rtl/accel_spi_reader.sv
// ADXL362 front-end: SPI mode-0 master that writes POWER_CTL once after power-up,
// then periodically burst-reads XDATA/YDATA into registered signed tilt outputs.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV        = 50,
  parameter int unsigned STARTUP_CYCLES = 600000,
  parameter int unsigned SAMPLE_CYCLES  = 1666667,
  parameter int unsigned CS_GAP         = 50
) (
  input  logic       CLK,
  input  logic       rst_n,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic [7:0] accel_x,
  output logic [7:0] accel_y,
  output logic       accel_valid,
  output logic       cfg_done
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BOOT_W = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned SAMP_W = $clog2(SAMPLE_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(STARTUP_CYCLES - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);

  // write 0x02 to POWER_CTL (0x2D); read starting at XDATA (0x08) with two dummy bytes
  localparam logic [31:0] CFG_WORD  = 32'h0A2D_0200;
  localparam logic [31:0] READ_WORD = 32'h0B08_0000;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_CFG    = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;
  localparam logic [2:0] ST_UPDATE = 3'd5;

  logic [2:0]        state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [SAMP_W-1:0] samp_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic [4:0]        last_bit;
  logic [31:0]       tx_sr;
  logic [15:0]       rx_sr;

  always_comb begin
    last_bit = 5'd23;
    if (state == ST_READ) last_bit = 5'd31;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      samp_cnt    <= '0;
      gap_cnt     <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      mosi        <= 1'b0;
      accel_x     <= '0;
      accel_y     <= '0;
      accel_valid <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      accel_valid <= 1'b0;
      // free-running; cleared at CFG end and at each READ start, so it only matters in WAIT
      samp_cnt    <= samp_cnt + 1'b1;

      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state   <= ST_CFG;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= CFG_WORD[31];
            tx_sr   <= {CFG_WORD[30:0], 1'b0};
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end

        ST_CFG, ST_READ: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[14:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == last_bit) begin
                cs_n    <= 1'b1;
                mosi    <= 1'b0;
                gap_cnt <= '0;
                if (state == ST_CFG) begin
                  cfg_done <= 1'b1;
                  samp_cnt <= '0;
                  state    <= ST_GAP;
                end else begin
                  state <= ST_UPDATE;
                end
              end else begin
                mosi    <= tx_sr[31];
                tx_sr   <= {tx_sr[30:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        ST_UPDATE: begin
          accel_x     <= rx_sr[15:8];
          accel_y     <= rx_sr[7:0];
          accel_valid <= 1'b1;
          gap_cnt     <= '0;
          state       <= ST_GAP;
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_WAIT;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        ST_WAIT: begin
          if (samp_cnt == SAMP_LAST) begin
            state    <= ST_READ;
            samp_cnt <= '0;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= READ_WORD[31];
            tx_sr    <= {READ_WORD[30:0], 1'b0};
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: ADXL362-like SPI slave model plus a scoreboard of
// expected X/Y samples, with protocol timing and mode-0 checks.
module tb_accel_spi_reader;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       miso = 1'b0;
  logic       sclk, cs_n, mosi;
  logic [7:0] accel_x, accel_y;
  logic       accel_valid, cfg_done;

  accel_spi_reader #(
    .CLK_DIV       (2),
    .STARTUP_CYCLES(10),
    .SAMPLE_CYCLES (200),
    .CS_GAP        (4)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_valid(accel_valid),
    .cfg_done   (cfg_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] tab_x [6] = '{8'h7F, 8'hFF, 8'h00, 8'h5A, 8'h33, 8'hC4};
  logic [7:0] tab_y [6] = '{8'h80, 8'h01, 8'hFE, 8'hA5, 8'hCC, 8'h3B};

  logic [15:0] sb [$];
  int pushes = 0;
  int pops = 0;
  int rd_idx = 0;

  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_valid = 1'b0;
  int          fall_cyc = 0, rise_cyc = 0, last_read_fall = -1, cfg_rise = 0;
  int          rises = 0, bit_idx = 0;
  logic [31:0] cap = '0;
  logic [15:0] sdata = '0;
  logic [15:0] exp_xy;
  bit          expect_cfg = 1'b1;
  logic [7:0]  held_x = '0, held_y = '0;
  int          mode_err = 0, idle_err = 0, dbl_err = 0, unstable_err = 0;

  // command/address bit times are driven as 1s so leakage into the outputs shows up
  function automatic logic miso_bit(input int idx, input logic [15:0] d);
    if (idx < 16) return 1'b1;
    return d[31-idx];
  endfunction

  always @(posedge CLK) begin
    #1;
    if (!rst_n) begin
      sb.delete();
      expect_cfg     = 1'b1;
      held_x         = '0;
      held_y         = '0;
      last_read_fall = -1;
      miso           = 1'b0;
    end else begin
      if (cs_n && sclk) idle_err++;
      if (prev_sclk && sclk && (mosi !== prev_mosi)) mode_err++;

      if (prev_cs && !cs_n) begin
        fall_cyc = cyc;
        rises    = 0;
        cap      = '0;
        bit_idx  = 0;
        if (expect_cfg) begin
          chk("cfg_done_before_cfg", cfg_done, 1'b0);
          sdata = 16'h0000;
        end else begin
          sdata = {tab_x[rd_idx % 6], tab_y[rd_idx % 6]};
          rd_idx++;
          sb.push_back(sdata);
          pushes++;
          if (last_read_fall >= 0) chk("read_period", cyc - last_read_fall, 200);
          else chk("first_read_delay", cyc - cfg_rise, 200);
          last_read_fall = cyc;
        end
        miso = miso_bit(0, sdata);
      end else if (!cs_n && !prev_sclk && sclk) begin
        cap = {cap[30:0], mosi};
        rises++;
      end else if (!cs_n && prev_sclk && !sclk) begin
        bit_idx++;
        miso = miso_bit(bit_idx, sdata);
      end else if (!prev_cs && cs_n) begin
        rise_cyc = cyc;
        miso     = 1'b0;
        if (expect_cfg) begin
          chk("cfg_rises", rises, 24);
          chk("cfg_word", cap, 32'h000A_2D02);
          chk("cfg_len", cyc - fall_cyc, 96);
          chk("cfg_done_at_end", cfg_done, 1'b1);
          cfg_rise   = cyc;
          expect_cfg = 1'b0;
        end else begin
          chk("read_rises", rises, 32);
          chk("read_word", cap, 32'h0B08_0000);
          chk("read_len", cyc - fall_cyc, 128);
        end
      end

      if (accel_valid) begin
        if (prev_valid) dbl_err++;
        chk("valid_latency", cyc - rise_cyc, 1);
        if (sb.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          exp_xy = sb.pop_front();
          pops++;
          chk("accel_x", accel_x, exp_xy[15:8]);
          chk("accel_y", accel_y, exp_xy[7:0]);
        end
        held_x = accel_x;
        held_y = accel_y;
      end else if ((accel_x !== held_x) || (accel_y !== held_y)) begin
        unstable_err++;
      end
    end
    prev_cs    = cs_n;
    prev_sclk  = sclk;
    prev_mosi  = mosi;
    prev_valid = accel_valid;
  end

  task automatic wait_boot(input string tag);
    int n = 0;
    while (n < 50) begin
      @(posedge CLK);
      #2;
      n++;
      if (!cs_n) break;
    end
    chk(tag, n, 10);
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    int k = 0;
    while (pops < target && k < budget) begin
      @(posedge CLK);
      k++;
    end
    #2;
    chk(tag, pops >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1'b1);
    chk({tag, "_sclk"}, sclk, 1'b0);
    chk({tag, "_mosi"}, mosi, 1'b0);
    chk({tag, "_accel_x"}, accel_x, 8'h00);
    chk({tag, "_accel_y"}, accel_y, 8'h00);
    chk({tag, "_valid"}, accel_valid, 1'b0);
    chk({tag, "_cfg_done"}, cfg_done, 1'b0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");

    rst_n = 1'b1;
    wait_boot("boot_wait");
    wait_pops("four_samples", 4, 3000);

    k = 0;
    while (cs_n && k < 400) begin
      @(posedge CLK);
      k++;
    end
    #2;
    chk("read5_start", cs_n, 1'b0);
    repeat (60) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");

    repeat (5) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    wait_boot("boot_wait_after_reset");
    wait_pops("samples_after_reset", pops + 2, 1500);

    chk("mosi_change_sclk_high", mode_err, 0);
    chk("sclk_high_cs_idle", idle_err, 0);
    chk("valid_multi_cycle", dbl_err, 0);
    chk("outputs_unstable", unstable_err, 0);
    chk("sb_pending", sb.size(), 0);

    repeat (5) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

Front-end reader for the on-board ADXL362 accelerometer. Acts as SPI master (mode 0) and configures the sensor into measurement mode after reset. It then periodically burst-reads the 8-bit X and Y acceleration registers. Its registered `accel_x` / `accel_y` outputs are the signed 8-bit tilt values the ball-motion block consumes.

## Interface
- `CLK_DIV`, 50: CLK cycles per SCLK half-period (100 MHz CLK gives 1 MHz SCLK); must be ≥ 2.
- `STARTUP_CYCLES`, 600000: CLK cycles idle after reset before the first transaction (6 ms sensor power-up).
- `SAMPLE_CYCLES`, 1666667: CLK cycles between read-transaction starts (60 Hz); must be ≥ 64·CLK_DIV + CS_GAP + 2.
- `CS_GAP`, 50: minimum CLK cycles `cs_n` stays high between transactions.

Ports:
- `CLK`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sclk`, out, 1: SPI clock; idles low.
- `cs_n`, out, 1: sensor chip select, active low.
- `mosi`, out, 1: command/address/data to the sensor, MSB first.
- `miso`, in, 1: sensor data, sampled on SCLK rising edges.
- `accel_x`, out, 8: last X sample, two's complement (XDATA, 0x08).
- `accel_y`, out, 8: last Y sample, two's complement (YDATA, 0x09).
- `accel_valid`, out, 1: one-CLK pulse when `accel_x` / `accel_y` update.
- `cfg_done`, out, 1: high once the configuration write has completed; stays high until reset.

## Operation
- Reset values (applied asynchronously while `rst_n` = 0):
  - `sclk` = 0, `cs_n` = 1, `mosi` = 0.
  - `accel_x` = `accel_y` = 0, `accel_valid` = 0, `cfg_done` = 0.
  - All counters cleared; state = BOOT.
- States:
  - BOOT: count `STARTUP_CYCLES`, then go to CFG.
  - CFG: 24-bit write frame 0x0A, 0x2D, 0x02 (POWER_CTL = measurement mode). At frame end, set `cfg_done` and go to GAP.
  - GAP: `cs_n` high for `CS_GAP` cycles, then go to WAIT.
  - WAIT: go to READ when the sample timer expires.
  - READ: 32-bit frame 0x0B, 0x08, then two dummy bytes on `mosi` (0x00). MISO bits 16–23 form X and bits 24–31 form Y. At frame end, go to UPDATE.
  - UPDATE: load `accel_x` / `accel_y` from the shift register, pulse `accel_valid`, then go to GAP.
- Sample timer:
  - Starts counting when CFG completes.
  - Reloads at every READ entry, so READ starts are exactly `SAMPLE_CYCLES` apart.
  - The first READ starts `SAMPLE_CYCLES` after CFG completes.
- Shift registers: one 32-bit register shifts out on `mosi`; a separate 16-bit register shifts in from `miso`. Only the last 16 received bits are kept. Bits received during the command and address bytes are discarded.
- `accel_x` / `accel_y` hold their value between updates. No partial update ever occurs: both change on the same cycle.
- Reset asserted mid-frame aborts the frame: `cs_n` rises immediately and the outputs take their reset values. After release the block restarts from BOOT, including the configuration write.

## Timing
- Frame start (cycle t): `cs_n` falls, `sclk` = 0, and `mosi` carries the MSB.
- Each bit lasts 2·CLK_DIV cycles:
  - `sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `miso` is captured on the CLK edge where `sclk` goes high.
  - `mosi` changes only on the edge where `sclk` goes low (and at frame start).
- Frame end: an N-bit frame holds `cs_n` low for exactly 2·N·CLK_DIV cycles. `cs_n` rises on the same edge `sclk` returns low; no extra SCLK edges occur.
- Readout latency: `accel_valid` is high the cycle after `cs_n` rises at READ end, concurrent with the new `accel_x` / `accel_y` values.
- `cfg_done` rises on the same edge `cs_n` rises at CFG end.
- Gap: `cs_n` high time between frames is ≥ `CS_GAP` cycles.

## Test plan
The bench uses CLK_DIV = 2, STARTUP_CYCLES = 10, SAMPLE_CYCLES = 200, CS_GAP = 4.

- Reset release → `cs_n` stays 1 for 10 cycles, then falls. The sensor model captures 24 bits = 0x0A2D02 over 96 cycles. `cfg_done` rises as `cs_n` rises.
- Sensor model returns X = 0x7F, Y = 0x80 → the first READ frame carries `mosi` 0x0B08_0000. `cs_n` is low for 128 cycles. One cycle after `cs_n` rises, `accel_x` = 0x7F, `accel_y` = 0x80, and `accel_valid` is high for exactly 1 cycle.
- Periodicity: successive `cs_n` falling edges of READ frames are exactly 200 cycles apart. `accel_valid` pulses once per frame, and the outputs are stable between pulses.
- SPI mode-0 check: `mosi` never changes while `sclk` = 1. `sclk` is 0 whenever `cs_n` = 1. Each frame has exactly N rising edges (24 or 32).
- Model returns X = 0xFF, Y = 0x01, then X = 0x00, Y = 0xFE → the outputs follow each frame. The command/address bits driven on `miso` (forced to 1s) never appear in the outputs.
- `rst_n` pulled low midway through a READ → `cs_n` = 1, `sclk` = 0, outputs = 0, and `cfg_done` = 0 immediately. After release, the full sequence repeats from the BOOT wait.
